// File: rtl/obj_cmd_pkg.sv
// Shared types and codes for the Nios object-command controller.
// Covers the object record, the packet opcodes, the handshake codes and the FSM states.
package obj_cmd_pkg;

    typedef struct packed {
        logic       en;
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] tile;
    } obj_t;

    localparam logic [3:0] OP_SET    = 4'd1;
    localparam logic [3:0] OP_HIDE   = 4'd2;
    localparam logic [3:0] OP_SCROLL = 4'd3;

    // to_hw_sig codes (software -> hardware)
    localparam logic [1:0] HS_IDLE   = 2'b00;
    localparam logic [1:0] HS_DATA   = 2'b01;
    localparam logic [1:0] HS_COMMIT = 2'b10;
    localparam logic [1:0] HS_RST    = 2'b11;

    // to_sw_sig codes (hardware -> software)
    localparam logic [1:0] SW_READY  = 2'b00;
    localparam logic [1:0] SW_ACK    = 2'b01;
    localparam logic [1:0] SW_BUSY   = 2'b10;
    localparam logic [1:0] SW_ERR    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_BUSY,
        ST_ERR
    } state_t;

endpackage

// File: rtl/obj_table_dbuf.sv
// Double-buffered object table: software writes the shadow copy, and the whole
// shadow (slots plus scroll) is copied to the active copy on vertical-blank entry.
module obj_table_dbuf
    import obj_cmd_pkg::*;
#(
    parameter int NUM_OBJ  = 16,
    parameter int IDX_W    = 4,
    parameter int V_ACTIVE = 480
) (
    input  logic             clk50,
    input  logic             reset,
    input  logic [9:0]       vc,
    input  logic             commit_pending,
    input  logic             wr_en,
    input  logic [3:0]       wr_op,
    input  logic [IDX_W-1:0] wr_idx,
    input  obj_t             wr_obj,
    input  logic [IDX_W-1:0] rd_idx,
    output obj_t             rd_obj,
    output logic [9:0]       scroll_x,
    output logic             swap,
    output logic [7:0]       frame_cnt
);

    obj_t       shadow [NUM_OBJ];
    obj_t       active [NUM_OBJ];
    logic [9:0] shadow_scroll;
    logic       vblank;
    logic       vblank_d;

    assign vblank = (vc >= 10'(V_ACTIVE));
    assign swap   = vblank && !vblank_d && commit_pending;

    // NOTE: both tables are cleared on reset so the renderer starts with every object hidden.
    always_ff @(posedge clk50) begin
        if (reset) begin
            shadow        <= '{default: '0};
            active        <= '{default: '0};
            shadow_scroll <= '0;
            scroll_x      <= '0;
            vblank_d      <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            vblank_d <= vblank;
            if (wr_en) begin
                case (wr_op)
                    OP_SET:    shadow[wr_idx]    <= wr_obj;
                    OP_HIDE:   shadow[wr_idx].en <= 1'b0;
                    OP_SCROLL: shadow_scroll     <= wr_obj.x;
                    default:   ;
                endcase
            end
            // Shadow is kept after the swap so software only sends deltas.
            if (swap) begin
                active    <= shadow;
                scroll_x  <= shadow_scroll;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    assign rd_obj = active[rd_idx];

endmodule

// File: rtl/nios_obj_cmd_ctrl.sv
// Nios PIO command controller: four-phase handshake FSM and 4-byte packet
// assembler feeding the double-buffered object table.
module nios_obj_cmd_ctrl
    import obj_cmd_pkg::*;
#(
    parameter int NUM_OBJ  = 16,
    parameter int IDX_W    = 4,
    parameter int V_ACTIVE = 480
) (
    input  logic             clk50,
    input  logic             reset,
    input  logic [1:0]       to_hw_sig,
    input  logic [7:0]       to_hw_data,
    output logic [1:0]       to_sw_sig,
    input  logic [9:0]       vc,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             obj_en,
    output logic [9:0]       obj_x,
    output logic [9:0]       obj_y,
    output logic [3:0]       obj_tile,
    output logic [9:0]       scroll_x,
    output logic             commit_pending,
    output logic [7:0]       frame_cnt
);

    state_t     state, state_nxt;
    logic [1:0] byte_cnt;
    logic [7:0] b0, b1, b2;
    logic       accept, commit_set, swap;
    logic       last_byte, op_ok, wr_en;
    logic [3:0] op;
    obj_t       wr_obj, rd_obj;

    assign last_byte = (byte_cnt == 2'd3);
    assign op        = b0[7:4];
    assign op_ok     = (op == OP_SET) || (op == OP_HIDE) || (op == OP_SCROLL);

    // The 4th byte comes straight from the bus so the packet applies on its accept edge.
    assign wr_obj = '{en: 1'b1, x: {b2[7:6], b1}, y: {b2[5:0], to_hw_data[7:4]},
                      tile: to_hw_data[3:0]};

    always_ff @(posedge clk50) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        commit_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (to_hw_sig == HS_DATA) begin
                    if (commit_pending) begin
                        state_nxt = ST_BUSY;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = (last_byte && !op_ok) ? ST_ERR : ST_ACK;
                    end
                end else if (to_hw_sig == HS_COMMIT) begin
                    if (byte_cnt != 2'd0) begin
                        state_nxt = ST_ERR;
                    end else if (commit_pending) begin
                        state_nxt = ST_BUSY;
                    end else begin
                        commit_set = 1'b1;
                        state_nxt  = ST_ACK;
                    end
                end
            end
            // Returning to IDLE lets a still-held request be re-examined after the swap.
            ST_BUSY: if (swap) state_nxt = ST_IDLE;
            ST_ACK, ST_ERR: if (to_hw_sig == HS_IDLE) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (to_hw_sig == HS_RST) state_nxt = ST_ACK;
    end

    always_comb begin
        to_sw_sig = SW_READY;
        case (state)
            ST_ACK:  to_sw_sig = SW_ACK;
            ST_BUSY: to_sw_sig = SW_BUSY;
            ST_ERR:  to_sw_sig = SW_ERR;
            default: to_sw_sig = SW_READY;
        endcase
        wr_en = accept && last_byte && op_ok;
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            byte_cnt       <= '0;
            commit_pending <= 1'b0;
        end else begin
            if (to_hw_sig == HS_RST) byte_cnt <= '0;
            else if (accept)         byte_cnt <= byte_cnt + 2'd1;
            if (commit_set)  commit_pending <= 1'b1;
            else if (swap)   commit_pending <= 1'b0;
        end
    end

    // NOTE: the byte slots need no reset; each is rewritten before the 4th byte reads it.
    always_ff @(posedge clk50) begin
        if (accept) begin
            case (byte_cnt)
                2'd0:    b0 <= to_hw_data;
                2'd1:    b1 <= to_hw_data;
                2'd2:    b2 <= to_hw_data;
                default: ;
            endcase
        end
    end

    obj_table_dbuf #(
        .NUM_OBJ (NUM_OBJ),
        .IDX_W   (IDX_W),
        .V_ACTIVE(V_ACTIVE)
    ) u_dbuf (
        .clk50         (clk50),
        .reset         (reset),
        .vc            (vc),
        .commit_pending(commit_pending),
        .wr_en         (wr_en),
        .wr_op         (op),
        .wr_idx        (b0[IDX_W-1:0]),
        .wr_obj        (wr_obj),
        .rd_idx        (rd_idx),
        .rd_obj        (rd_obj),
        .scroll_x      (scroll_x),
        .swap          (swap),
        .frame_cnt     (frame_cnt)
    );

    assign obj_en   = rd_obj.en;
    assign obj_x    = rd_obj.x;
    assign obj_y    = rd_obj.y;
    assign obj_tile = rd_obj.tile;

endmodule

// File: tb/tb_nios_obj_cmd_ctrl.sv
// Self-checking bench for nios_obj_cmd_ctrl: decode vector table, handshake
// corner sequences, then random traffic against a transaction-level model.
module tb_nios_obj_cmd_ctrl;
    import obj_cmd_pkg::*;

    logic       clk50 = 1'b0;
    logic       reset;
    logic [1:0] to_hw_sig;
    logic [7:0] to_hw_data;
    logic [1:0] to_sw_sig;
    logic [9:0] vc;
    logic [3:0] rd_idx;
    logic       obj_en;
    logic [9:0] obj_x, obj_y, scroll_x;
    logic [3:0] obj_tile;
    logic       commit_pending;
    logic [7:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int fexp     = 0;

    nios_obj_cmd_ctrl dut (
        .clk50(clk50), .reset(reset), .to_hw_sig(to_hw_sig), .to_hw_data(to_hw_data),
        .to_sw_sig(to_sw_sig), .vc(vc), .rd_idx(rd_idx), .obj_en(obj_en), .obj_x(obj_x),
        .obj_y(obj_y), .obj_tile(obj_tile), .scroll_x(scroll_x),
        .commit_pending(commit_pending), .frame_cnt(frame_cnt)
    );

    always #5 clk50 = ~clk50;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] bytes;
        logic [1:0]  last_resp;
        logic [3:0]  idx;
        logic        en;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [3:0]  tile;
        logic [9:0]  scroll;
    } vec_t;
    vec_t vecs[7];

    // Transaction-level model state
    int m_sh_en[16], m_sh_x[16], m_sh_y[16], m_sh_t[16];
    int m_ac_en[16], m_ac_x[16], m_ac_y[16], m_ac_t[16];
    int m_sc_sh, m_sc_ac, m_pend, m_frame, m_cnt;
    int m_pkt[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk50);
        #1;
    endtask

    task automatic release_hs(input string name);
        int n = 0;
        to_hw_sig = HS_IDLE;
        do begin step(); n++; end while (to_sw_sig != SW_READY && n < 20);
        check({name, "_rel"}, 32'(to_sw_sig), 32'(SW_READY));
    endtask

    task automatic hs(input logic [1:0] sig, input logic [7:0] data, input logic [1:0] exp,
                      input bit rel, input string name);
        int n = 0;
        to_hw_sig  = sig;
        to_hw_data = data;
        do begin step(); n++; end while (to_sw_sig == SW_READY && n < 20);
        check(name, 32'(to_sw_sig), 32'(exp));
        if (rel) release_hs(name);
    endtask

    task automatic vblank_swap();
        vc = 10'd479; step();
        vc = 10'd480; step(); step();
        vc = 10'd0;   step();
    endtask

    task automatic check_obj(input string name, input logic [3:0] idx, input logic en,
                             input logic [9:0] x, input logic [9:0] y, input logic [3:0] t);
        rd_idx = idx;
        #1;
        check({name, "_en"},   32'(obj_en),   32'(en));
        check({name, "_x"},    32'(obj_x),    32'(x));
        check({name, "_y"},    32'(obj_y),    32'(y));
        check({name, "_tile"}, 32'(obj_tile), 32'(t));
    endtask

    task automatic send_pkt(input logic [31:0] p, input string name);
        for (int k = 0; k < 4; k++) hs(HS_DATA, p[31-8*k -: 8], SW_ACK, 1'b1, name);
    endtask

    task automatic do_reset();
        reset = 1'b1; to_hw_sig = HS_IDLE; to_hw_data = '0; vc = '0; rd_idx = '0;
        step(); step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            m_sh_en[i] = 0; m_sh_x[i] = 0; m_sh_y[i] = 0; m_sh_t[i] = 0;
            m_ac_en[i] = 0; m_ac_x[i] = 0; m_ac_y[i] = 0; m_ac_t[i] = 0;
        end
        m_sc_sh = 0; m_sc_ac = 0; m_pend = 0; m_frame = 0; m_cnt = 0;
        fexp = 0;
    endtask

    task automatic m_byte(input logic [7:0] b, input string name);
        logic [1:0] e = SW_ACK;
        int op, idx;
        m_pkt[m_cnt] = b;
        if (m_cnt == 3) begin
            op  = m_pkt[0] / 16;
            idx = m_pkt[0] % 16;
            if (op == 1) begin
                m_sh_en[idx] = 1;
                m_sh_x[idx]  = m_pkt[1] + 256 * (m_pkt[2] / 64);
                m_sh_y[idx]  = (m_pkt[2] % 64) * 16 + m_pkt[3] / 16;
                m_sh_t[idx]  = m_pkt[3] % 16;
            end else if (op == 2) m_sh_en[idx] = 0;
            else if (op == 3) m_sc_sh = m_pkt[1] + 256 * (m_pkt[2] / 64);
            else e = SW_ERR;
        end
        m_cnt = (m_cnt + 1) % 4;
        hs(HS_DATA, b, e, 1'b1, name);
    endtask

    task automatic m_commit(input string name);
        logic [1:0] e = (m_cnt != 0) ? SW_ERR : SW_ACK;
        if (e == SW_ACK) m_pend = 1;
        hs(HS_COMMIT, 8'h00, e, 1'b1, name);
    endtask

    task automatic m_swap_check(input string name);
        vblank_swap();
        if (m_pend != 0) begin
            for (int i = 0; i < 16; i++) begin
                m_ac_en[i] = m_sh_en[i]; m_ac_x[i] = m_sh_x[i];
                m_ac_y[i]  = m_sh_y[i];  m_ac_t[i] = m_sh_t[i];
            end
            m_sc_ac = m_sc_sh; m_frame = (m_frame + 1) % 256; m_pend = 0;
        end
        for (int i = 0; i < 16; i++)
            check_obj($sformatf("%s_obj%0d", name, i), 4'(i), 1'(m_ac_en[i]),
                      10'(m_ac_x[i]), 10'(m_ac_y[i]), 4'(m_ac_t[i]));
        check({name, "_scroll"},  32'(scroll_x),       32'(m_sc_ac));
        check({name, "_frame"},   32'(frame_cnt),      32'(m_frame));
        check({name, "_pending"}, 32'(commit_pending), 32'(m_pend));
    endtask

    initial begin
        int cnt;
        vecs[0] = '{32'h13554F07, SW_ACK, 4'd3,  1'b1, 10'd341,   10'd240,   4'd7,  10'd0};
        vecs[1] = '{32'h1AFFFFFF, SW_ACK, 4'd10, 1'b1, 10'h3FF,   10'h3FF,   4'hF,  10'd0};
        vecs[2] = '{32'h23000000, SW_ACK, 4'd3,  1'b0, 10'd341,   10'd240,   4'd7,  10'd0};
        vecs[3] = '{32'h302A8000, SW_ACK, 4'd10, 1'b1, 10'h3FF,   10'h3FF,   4'hF,  10'h22A};
        vecs[4] = '{32'h53000000, SW_ERR, 4'd3,  1'b0, 10'd341,   10'd240,   4'd7,  10'h22A};
        vecs[5] = '{32'h10000001, SW_ACK, 4'd0,  1'b1, 10'd0,     10'd0,     4'd1,  10'h22A};
        vecs[6] = '{32'h1F010010, SW_ACK, 4'd15, 1'b1, 10'd1,     10'd1,     4'd0,  10'h22A};

        do_reset();
        check("rst_sw_sig",  32'(to_sw_sig),      32'(SW_READY));
        check("rst_pending", 32'(commit_pending), 32'd0);
        check("rst_frame",   32'(frame_cnt),      32'd0);
        check("rst_scroll",  32'(scroll_x),       32'd0);
        check_obj("rst_obj3", 4'd3, 1'b0, 10'd0, 10'd0, 4'd0);

        // Decode table: packet, commit, swap, then read back one slot
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 4; k++)
                hs(HS_DATA, vecs[i].bytes[31-8*k -: 8], (k == 3) ? vecs[i].last_resp : SW_ACK,
                   1'b1, $sformatf("vec%0d_b%0d", i, k));
            hs(HS_COMMIT, 8'h00, SW_ACK, 1'b1, $sformatf("vec%0d_commit", i));
            vblank_swap();
            fexp++;
            check_obj($sformatf("vec%0d", i), vecs[i].idx, vecs[i].en, vecs[i].x, vecs[i].y,
                      vecs[i].tile);
            check($sformatf("vec%0d_scroll", i),  32'(scroll_x),       32'(vecs[i].scroll));
            check($sformatf("vec%0d_frame", i),   32'(frame_cnt),      32'(fexp));
            check($sformatf("vec%0d_pending", i), 32'(commit_pending), 32'd0);
        end

        // Level-held data bytes: one ack each, ready only after release
        begin
            logic [31:0] p = 32'h1534123C;
            for (int k = 0; k < 4; k++) begin
                to_hw_sig = HS_DATA; to_hw_data = p[31-8*k -: 8];
                cnt = 0;
                for (int c = 0; c < 10; c++) begin
                    step();
                    if (to_sw_sig == SW_ACK) cnt++;
                end
                check($sformatf("hold_b%0d_acks", k), 32'(cnt), 32'd10);
                to_hw_sig = HS_IDLE; step();
                check($sformatf("hold_b%0d_ready", k), 32'(to_sw_sig), 32'(SW_READY));
            end
            hs(HS_COMMIT, 8'h00, SW_ACK, 1'b1, "hold_commit");
            vblank_swap(); fexp++;
            check_obj("hold_obj5", 4'd5, 1'b1, 10'h034, 10'h123, 4'hC);
            check("hold_frame", 32'(frame_cnt), 32'(fexp));
        end

        // Bad opcode answered with error, cleared by stream reset
        for (int k = 0; k < 3; k++) hs(HS_DATA, (k == 0) ? 8'h53 : 8'h00, SW_ACK, 1'b1, "bad_b");
        hs(HS_DATA, 8'h00, SW_ERR, 1'b0, "bad_b3");
        to_hw_sig = HS_RST;
        cnt = 0;
        do begin step(); cnt++; end while (to_sw_sig != SW_ACK && cnt < 20);
        check("bad_rst_ack", 32'(to_sw_sig), 32'(SW_ACK));
        release_hs("bad_rst");
        send_pkt(32'h190A0005, "bad_next");
        hs(HS_COMMIT, 8'h00, SW_ACK, 1'b1, "bad_commit");
        vblank_swap(); fexp++;
        check_obj("bad_obj9", 4'd9, 1'b1, 10'h00A, 10'd0, 4'd5);
        check_obj("bad_obj3", 4'd3, 1'b0, 10'd341, 10'd240, 4'd7);

        // Data while a commit is pending: busy, then acked after the swap
        vc = 10'd100;
        hs(HS_COMMIT, 8'h00, SW_ACK, 1'b1, "busy_commit");
        hs(HS_DATA, 8'h16, SW_BUSY, 1'b0, "busy_sig");
        step(); step(); step();
        check("busy_hold", 32'(to_sw_sig), 32'(SW_BUSY));
        check("busy_pending", 32'(commit_pending), 32'd1);
        vc = 10'd480;
        cnt = 0;
        do begin step(); cnt++; end while (to_sw_sig != SW_ACK && cnt < 20);
        check("busy_late_ack", 32'(to_sw_sig), 32'(SW_ACK));
        fexp++;
        check("busy_frame", 32'(frame_cnt), 32'(fexp));
        check("busy_pending_clr", 32'(commit_pending), 32'd0);
        check_obj("busy_not_active", 4'd6, 1'b0, 10'd0, 10'd0, 4'd0);
        release_hs("busy_b0");
        for (int k = 0; k < 3; k++)
            hs(HS_DATA, (k == 0) ? 8'h20 : ((k == 1) ? 8'h00 : 8'h03), SW_ACK, 1'b1, "busy_rest");
        hs(HS_COMMIT, 8'h00, SW_ACK, 1'b1, "busy_commit2");
        vblank_swap(); fexp++;
        check_obj("busy_obj6", 4'd6, 1'b1, 10'h020, 10'd0, 4'd3);

        // Commit accepted inside vblank waits for the next vblank entry
        vc = 10'd490; step(); step();
        hs(HS_COMMIT, 8'h00, SW_ACK, 1'b1, "vbl_commit");
        for (int c = 0; c < 5; c++) step();
        check("vbl_wait_pending", 32'(commit_pending), 32'd1);
        check("vbl_wait_frame",   32'(frame_cnt),      32'(fexp));
        vc = 10'd0; step();
        vc = 10'd480; step(); step(); fexp++;
        check("vbl_pending", 32'(commit_pending), 32'd0);
        check("vbl_frame",   32'(frame_cnt),      32'(fexp));
        vc = 10'd0; step();

        // Commit mid-packet is an error and leaves nothing pending
        hs(HS_DATA, 8'h11, SW_ACK, 1'b1, "part_b0");
        hs(HS_DATA, 8'h22, SW_ACK, 1'b1, "part_b1");
        hs(HS_COMMIT, 8'h00, SW_ERR, 1'b1, "part_commit");
        check("part_pending", 32'(commit_pending), 32'd0);
        hs(HS_RST, 8'h00, SW_ACK, 1'b1, "part_rst");

        // Reset mid-packet drops the partial packet
        hs(HS_DATA, 8'h12, SW_ACK, 1'b1, "mid_b0");
        hs(HS_DATA, 8'h33, SW_ACK, 1'b1, "mid_b1");
        do_reset();
        check("mid_sw_sig",  32'(to_sw_sig),      32'(SW_READY));
        check("mid_pending", 32'(commit_pending), 32'd0);
        check("mid_frame",   32'(frame_cnt),      32'd0);
        check("mid_scroll",  32'(scroll_x),       32'd0);
        check_obj("mid_obj3", 4'd3, 1'b0, 10'd0, 10'd0, 4'd0);
        send_pkt(32'h12338AB9, "mid_pkt");
        hs(HS_COMMIT, 8'h00, SW_ACK, 1'b1, "mid_commit");
        vblank_swap();
        check_obj("mid_obj2", 4'd2, 1'b1, 10'h233, 10'h0AB, 4'h9);
        check("mid_frame1", 32'(frame_cnt), 32'd1);

        // Random traffic against the model
        do_reset();
        for (int it = 0; it < 40; it++) begin
            int r = $urandom_range(0, 9);
            if (r < 6) begin
                int s = $urandom_range(0, 9);
                logic [3:0] op;
                if (s == 0)     op = 4'($urandom_range(4, 15));
                else if (s < 6) op = OP_SET;
                else if (s < 8) op = OP_HIDE;
                else            op = OP_SCROLL;
                m_byte({op, 4'($urandom_range(0, 15))}, "rnd_b0");
                for (int k = 1; k < 4; k++) m_byte(8'($urandom), "rnd_b");
            end else if (r == 6) begin
                int n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) m_byte(8'($urandom), "rnd_part");
                m_commit("rnd_part_commit");
                hs(HS_RST, 8'h00, SW_ACK, 1'b1, "rnd_part_rst");
                m_cnt = 0;
            end else begin
                m_commit("rnd_commit");
                m_swap_check("rnd_swap");
            end
        end
        m_commit("rnd_final_commit");
        m_swap_check("rnd_final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
